sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Serial-in, parallel-out deserializer. It is the receive-side counterpart to the team's 4-bit parallel-load shift register. It collects a qualified serial bit stream into WIDTH-bit words and presents each completed word on a held parallel output with a valid/ack handshake. It sits between a serial link and the parallel consumer logic, and detects overrun when the consumer is slow.

Parameters:
WIDTH, 4, data bits per frame (legal range 2..32)
LSB_FIRST, 1, 1 = first received bit lands in par_out[0]; 0 = first bit lands in par_out[WIDTH-1]

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
sin  input  1  serial data bit
sin_valid  input  1  sin is sampled on this clock edge when high
clear  input  1  synchronous abort of the partial frame
par_ack  input  1  consumer accepts the current par_out word
par_out  output  WIDTH  last completed word, held until the next completion
par_valid  output  1  par_out holds an unacknowledged word
busy  output  1  partial frame in progress (bit count != 0)
bit_cnt  output  clog2(WIDTH+1)  bits received in the current frame
overrun  output  1  sticky: a word was overwritten before par_ack
par_err  output  1  parity error flag for the par_out word (optional feature)

Behaviour:
- Reset (rst=1, async): shift reg=0, bit_cnt=0, par_out=0, par_valid=0, busy=0, overrun=0, par_err=0. Reset asserted mid-frame discards the partial frame immediately.
- States: IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<frame length). busy=1 exactly in SHIFT.
- Each edge with sin_valid=1 shifts sin in and increments bit_cnt. Cycles with sin_valid=0 hold all state, so gaps inside a frame are legal.
- LSB_FIRST=1: the register shifts right and new bits enter at the MSB, so after WIDTH bits the first bit sits at bit 0. LSB_FIRST=0: the register shifts left and new bits enter at bit 0.
- Completion: an edge where sin_valid=1 and bit_cnt = frame length-1. On that edge:
  - par_out takes the full assembled word, including the current bit.
  - par_valid is set to 1.
  - bit_cnt returns to 0.
- Latency: the word is visible on par_out and par_valid the cycle after the last bit edge. Back-to-back frames need no idle cycle.
- Handshake: par_valid clears on an edge with par_ack=1 and no simultaneous completion. par_ack while par_valid=0 is ignored.
- Completion with par_valid=1 and par_ack=0: the new word overwrites par_out, par_valid stays 1, and overrun is set.
- Completion and par_ack on the same edge: this is not an overrun. The new word loads and par_valid stays 1.
- overrun clears only on rst.
- clear=1: bit_cnt=0 and shift reg=0. par_out, par_valid and overrun are unchanged. clear has priority over sin_valid on the same edge.
- Frame length = WIDTH, or WIDTH+1 with the optional feature.

Optional Feature:
Macro: SIPO_PARITY_EN
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, so frame length = WIDTH+1.
  - The parity bit is not stored in par_out.
  - par_err is loaded on completion: par_err = XOR of the data bits XOR the parity bit.
  - par_err holds and updates alongside par_out; clear does not change it.
  - bit_cnt counts up to WIDTH.
- Not defined: frame length = WIDTH and par_err is tied to 0.

Test Plan:
1. WIDTH=4, LSB_FIRST=1: sin 1,1,0,0 with sin_valid=1 on four consecutive edges -> par_out=4'b0011 and par_valid=1 on the 5th cycle; busy=0; bit_cnt=0.
2. Back-to-back frames 1,1,1,0 then 0,0,1,1 with no par_ack -> first word 4'b0111, then 4'b1100; overrun=1 after the second completion.
3. Gapped frame 0,1,0,1 with sin_valid low for 3 cycles between bits 2 and 3 -> par_out=4'b1010; bit_cnt holds at 2 during the gap.
4. After 2 bits assert clear, then send 1,0,0,1 -> par_out=4'b1001; the discarded bits have no effect; par_out is unchanged during clear.
5. Assert rst asynchronously mid-frame (between clock edges, bit_cnt=3) -> all outputs 0 immediately. The next full frame 1,0,1,1 -> 4'b1101.
6. With SIPO_PARITY_EN defined: data 1,1,0,0 plus parity 0 -> par_out=4'b0011, par_err=0. Same data with parity 1 -> par_err=1.

Source files
------------

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer with valid/ack output handshake and sticky overrun.
// Optional even-parity trailer bit per frame enabled by defining SIPO_PARITY_EN.
module sipo_deser #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sin,
  input  logic                           sin_valid,
  input  logic                           clear,
  input  logic                           par_ack,
  output logic [WIDTH-1:0]               par_out,
  output logic                           par_valid,
  output logic                           busy,
  output logic [$clog2(WIDTH+1)-1:0]     bit_cnt,
  output logic                           overrun,
  output logic                           par_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   par_out_q, par_out_d;
  logic               par_valid_q, par_valid_d;
  logic               overrun_q, overrun_d;
  logic [WIDTH-1:0]   shifted;
  logic               last_bit;
`ifdef SIPO_PARITY_EN
  logic               par_err_q, par_err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  // Next-state, shift datapath and handshake bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;
`ifdef SIPO_PARITY_EN
    par_err_d   = par_err_q;
`endif

    if (LSB_FIRST) begin
      shifted = {sin, shift_q[WIDTH-1:1]};
    end else begin
      shifted = {shift_q[WIDTH-2:0], sin};
    end
    last_bit = !clear && sin_valid && (cnt_q == LAST_CNT);

    case (state_q)
      IDLE:    if (!clear && sin_valid) state_d = SHIFT;
      SHIFT:   if (clear || last_bit)   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (par_ack) begin
      par_valid_d = 1'b0;
    end

    if (clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (last_bit) begin
      cnt_d       = '0;
      shift_d     = '0;
      par_valid_d = 1'b1;
      if (par_valid_q && !par_ack) begin
        overrun_d = 1'b1;
      end
`ifdef SIPO_PARITY_EN
      // Final bit is the parity trailer; the data word is already assembled.
      par_out_d = shift_q;
      par_err_d = (^shift_q) ^ sin;
`else
      par_out_d = shifted;
`endif
    end else if (sin_valid) begin
      cnt_d   = cnt_q + CNT_W'(1);
      shift_d = shifted;
    end
  end

  assign par_out   = par_out_q;
  assign par_valid = par_valid_q;
  assign busy      = (state_q == SHIFT);
  assign bit_cnt   = cnt_q;
  assign overrun   = overrun_q;
`ifdef SIPO_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4, LSB_FIRST=1); frames carry a parity
// trailer when SIPO_PARITY_EN is defined.
module tb_sipo_deser;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);
`ifdef SIPO_PARITY_EN
  localparam int unsigned FLEN = W + 1;
  localparam bit          PAR  = 1'b1;
`else
  localparam int unsigned FLEN = W;
  localparam bit          PAR  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sin;
  logic          sin_valid;
  logic          clear;
  logic          par_ack;
  logic [W-1:0]  par_out;
  logic          par_valid;
  logic          busy;
  logic [CW-1:0] bit_cnt;
  logic          overrun;
  logic          par_err;

  sipo_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clear(clear),
    .par_ack(par_ack), .par_out(par_out), .par_valid(par_valid), .busy(busy),
    .bit_cnt(bit_cnt), .overrun(overrun), .par_err(par_err)
  );

  always #5 clk = ~clk;

  // bits is written in send order: bits[0] goes on the wire first.
  typedef struct {
    logic [0:W-1] bits;
    logic [W-1:0] exp;
    bit           bad_par;
    int           gap_at;
    int           gap_len;
    bit           ack_last;
    bit           ack_after;
    bit           exp_ovr;
  } vec_t;

  typedef struct {
    logic [W-1:0] word;
    logic         err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [0:W-1] bits, input logic [W-1:0] exp,
                              input bit bad_par, input int gap_at, input int gap_len,
                              input bit ack_last, input bit ack_after, input bit exp_ovr);
    vec_t v;
    v.bits = bits; v.exp = exp; v.bad_par = bad_par; v.gap_at = gap_at;
    v.gap_len = gap_len; v.ack_last = ack_last; v.ack_after = ack_after; v.exp_ovr = exp_ovr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic b;
    exp_t e;
    for (int k = 0; k < int'(FLEN); k++) begin
      if (v.gap_len != 0 && k == v.gap_at) begin
        for (int g = 0; g < v.gap_len; g++) begin
          sin = 1'($urandom_range(0, 1));
          sin_valid = 1'b0;
          tick();
          chk("gap_bit_cnt", 32'(bit_cnt), 32'(k));
        end
      end
      if (k < int'(W)) b = v.bits[k];
      else             b = (^v.bits) ^ v.bad_par;
      if (k == int'(FLEN) - 1) begin
        e.word = v.exp;
        e.err  = PAR ? v.bad_par : 1'b0;
        sb.push_back(e);
        par_ack = v.ack_last;
      end
      sin = b;
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      par_ack = 1'b0;
      if (k < int'(FLEN) - 1) begin
        chk("mid_bit_cnt", 32'(bit_cnt), 32'(k + 1));
        chk("mid_busy", 32'(busy), 32'(1));
      end else if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: completion with empty expected queue");
      end else begin
        e = sb.pop_front();
        chk("par_out", 32'(par_out), 32'(e.word));
        chk("par_valid", 32'(par_valid), 32'(1));
        chk("done_busy", 32'(busy), 32'(0));
        chk("done_bit_cnt", 32'(bit_cnt), 32'(0));
        chk("par_err", 32'(par_err), 32'(e.err));
        chk("overrun", 32'(overrun), 32'(v.exp_ovr));
      end
    end
    if (v.ack_after) begin
      par_ack = 1'b1;
      tick();
      par_ack = 1'b0;
      chk("ack_valid", 32'(par_valid), 32'(0));
      chk("ack_held", 32'(par_out), 32'(v.exp));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_par_out"}, 32'(par_out), 32'(0));
    chk({tag, "_valid"}, 32'(par_valid), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_bit_cnt"}, 32'(bit_cnt), 32'(0));
    chk({tag, "_overrun"}, 32'(overrun), 32'(0));
    chk({tag, "_par_err"}, 32'(par_err), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                bits     exp      bad gapat gaplen ackl acka ovr
    tbl[0] = mk(4'b1100, 4'b0011, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    tbl[1] = mk(4'b1110, 4'b0111, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(4'b0011, 4'b1100, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    tbl[3] = mk(4'b0101, 4'b1010, 1'b0, 2, 3, 1'b0, 1'b0, 1'b1);

    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; clear = 1'b0; par_ack = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Partial frame aborted by clear, which outranks a simultaneous sin_valid.
    for (int i = 0; i < 2; i++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    chk("pre_clear_cnt", 32'(bit_cnt), 32'(2));
    clear = 1'b1;
    tick();
    clear = 1'b0; sin_valid = 1'b0;
    chk("clear_cnt", 32'(bit_cnt), 32'(0));
    chk("clear_busy", 32'(busy), 32'(0));
    chk("clear_par_out", 32'(par_out), 32'(4'b1010));
    chk("clear_valid", 32'(par_valid), 32'(1));
    chk("clear_overrun", 32'(overrun), 32'(1));
    run_vec(mk(4'b1001, 4'b1001, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1));

    // Async reset between edges with three bits of a frame collected.
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    chk("pre_rst_cnt", 32'(bit_cnt), 32'(3));
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #2 rst = 1'b0;
    run_vec(mk(4'b1011, 4'b1101, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0));

    // Completion coinciding with par_ack is not an overrun.
    run_vec(mk(4'b1100, 4'b0011, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0));

    // Ack clears valid; a second ack with nothing pending is ignored.
    par_ack = 1'b1;
    tick();
    chk("ack1_valid", 32'(par_valid), 32'(0));
    tick();
    par_ack = 1'b0;
    chk("ack2_valid", 32'(par_valid), 32'(0));
    chk("ack2_par_out", 32'(par_out), 32'(4'b0011));
    chk("ack2_overrun", 32'(overrun), 32'(0));

    // Bad parity trailer (flags par_err only in parity builds).
    run_vec(mk(4'b1100, 4'b0011, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0));
    run_vec(mk(4'b1100, 4'b0011, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0));

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
